// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
//   tx_state_t  : transmitter states IDLE/START/DATA/STOP
//   FRAME_BITS  : bits per 8N1 frame (start + 8 data + stop)
//   uart_byte_t : one data byte
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int unsigned FRAME_BITS = 10;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Byte FIFO storage: up to four bytes written per cycle, one byte read per cycle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   wr_cnt     : number of bytes to write this cycle (0..4), taken from wr_data[0..wr_cnt-1]
//   wr_data    : compacted write bytes, lane 0 written first
//   rd_en      : pop the head entry
//   rd_data    : current head entry (valid when count != 0)
//   count      : number of occupied entries
module uart_tx_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               wr_cnt,
  input  logic [3:0][7:0]          wr_data,
  input  logic                     rd_en,
  output uart_byte_t               rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  uart_byte_t        mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;

  // Pointers wrap naturally since DEPTH is a power of two; count separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(wr_cnt);
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_q + CW'(wr_cnt) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst && (3'(i) < wr_cnt)) mem[wr_ptr_q + PW'(i)] <= wr_data[i];
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO that accepts up to four byte lanes per write.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   wEn         : write strobe; enabled lanes are pushed all-or-nothing in ascending lane order
//   byte_en     : per-lane byte enables, lane k = data[8k+7:8k]
//   data        : write data
//   clr_ovf     : clears the sticky overflow flag (a same-cycle new overflow wins)
//   tx          : serial line, idle high, driven from a flop
//   busy        : FIFO non-empty or frame in progress (registered)
//   free_slots  : empty FIFO entries (registered)
//   overflow    : sticky flag set when a write is dropped (registered)
// Build option: define UART_TX_SIM_PRINT_EN to echo each byte to the console as it is popped.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wEn,
  input  logic [3:0]                    byte_en,
  input  logic [31:0]                   data,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   free_slots,
  output logic                          overflow
);

  localparam int unsigned SW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t       state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  uart_byte_t      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [SW-1:0]   free_q, free_d;
  logic            ovf_q, ovf_d;

  logic [2:0]      n_lanes;
  logic [3:0][7:0] packed_bytes;
  logic            push_ok;
  logic            drop;
  logic [2:0]      wr_cnt;
  logic            pop;
  uart_byte_t      rd_data;
  logic [SW-1:0]   fifo_count;

  // Compact enabled lanes to the bottom so the FIFO writes them in ascending lane order.
  always_comb begin
    n_lanes      = '0;
    packed_bytes = '0;
    for (int k = 0; k < 4; k++) begin
      if (byte_en[k]) begin
        packed_bytes[n_lanes[1:0]] = data[8*k +: 8];
        n_lanes = n_lanes + 3'd1;
      end
    end
  end

  // Space is judged against the registered free count, so a same-cycle pop does not help.
  assign push_ok = wEn && !rst && (SW'(n_lanes) <= free_q);
  assign drop    = wEn && !rst && (SW'(n_lanes) > free_q);
  assign wr_cnt  = push_ok ? n_lanes : 3'd0;

  uart_tx_fifo_mem #(
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_cnt  (wr_cnt),
    .wr_data (packed_bytes),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (fifo_count)
  );

  // tx_d is the line level for the next cycle, so tx changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_count != '0) begin
          pop     = 1'b1;
          shift_d = rd_data;
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'(FRAME_BITS - 3)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    free_d = free_q - SW'(wr_cnt) + SW'(pop);
    busy_d = (free_d != SW'(FIFO_DEPTH)) || (state_d != IDLE);
    ovf_d  = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      free_q  <= SW'(FIFO_DEPTH);
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      free_q  <= free_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef UART_TX_SIM_PRINT_EN
  always_ff @(posedge clk) begin
    if (!rst && pop) $write("%c", rd_data);
  end
`endif

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign free_slots = free_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a timeline/queue reference model predicts tx, busy,
// free_slots and overflow every cycle; a serial receiver decodes frames from tx and compares
// them with a scoreboard of accepted bytes.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int SW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wEn = 1'b0;
  logic [3:0]    byte_en = '0;
  logic [31:0]   data = '0;
  logic          clr_ovf = 1'b0;
  logic          tx;
  logic          busy;
  logic [SW-1:0] free_slots;
  logic          overflow;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wEn        (wEn),
    .byte_en    (byte_en),
    .data       (data),
    .clr_ovf    (clr_ovf),
    .tx         (tx),
    .busy       (busy),
    .free_slots (free_slots),
    .overflow   (overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q [$];   // scoreboard: accepted bytes not yet received
  int         fall_q [$];  // edge index of each observed start bit

  // Reference model: queue of bytes waiting, plus the edge at which the current frame began.
  logic [7:0] m_fifo [$];
  logic       m_ovf = 1'b0;
  int         last_pop = -1;
  int         tx_ready = 0;
  logic [7:0] cur_byte = '0;

  logic rst_edge = 1'b1;
  always @(posedge clk) rst_edge <= rst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: model the edge from the applied inputs, then compare outputs at the negedge.
  task automatic step();
    int n;
    int free;
    int o;
    logic e_tx;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_ovf    = 1'b0;
      last_pop = -1;
      tx_ready = 0;
    end else begin
      n    = $countones(byte_en);
      free = DEPTH - m_fifo.size();
      if (clr_ovf) m_ovf = 1'b0;
      if (wEn && n > free) m_ovf = 1'b1;
      if (m_fifo.size() > 0 && cyc >= tx_ready) begin
        cur_byte = m_fifo.pop_front();
        last_pop = cyc;
        tx_ready = cyc + 10*CPB + 1;
      end
      if (wEn && n > 0 && n <= free) begin
        for (int k = 0; k < 4; k++) begin
          if (byte_en[k]) begin
            m_fifo.push_back(data[8*k +: 8]);
            exp_q.push_back(data[8*k +: 8]);
          end
        end
      end
    end
    @(negedge clk);
    o = cyc - last_pop;
    if (last_pop < 0 || o >= 9*CPB) e_tx = 1'b1;
    else if (o < CPB)               e_tx = 1'b0;
    else                            e_tx = cur_byte[o/CPB - 1];
    chk("tx", tx, e_tx);
    chk("busy", busy, (m_fifo.size() > 0) || (last_pop >= 0 && o < 10*CPB));
    chk("free_slots", free_slots, DEPTH - m_fifo.size());
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic write(input logic [3:0] be, input logic [31:0] d, input logic clr);
    wEn = 1'b1; byte_en = be; data = d; clr_ovf = clr;
    step();
    wEn = 1'b0; byte_en = '0; clr_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    wEn = 1'b0; byte_en = '0; clr_ovf = 1'b0;
    repeat (n) step();
  endtask

  // Serial receiver: samples mid-bit, pops the scoreboard at each stop bit.
  initial begin
    int         ofs;
    bit         active;
    logic [7:0] rx;
    logic [7:0] e;
    ofs = 0; active = 0; rx = '0;
    forever begin
      @(negedge clk);
      if (rst_edge) begin
        active = 0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1; ofs = 0; rx = '0;
          fall_q.push_back(cyc);
        end
      end else begin
        ofs++;
      end
      if (active && !rst_edge && (ofs % CPB) == CPB/2) begin
        if (ofs/CPB >= 1 && ofs/CPB <= 8) begin
          rx[ofs/CPB - 1] = tx;
        end else if (ofs/CPB == 9) begin
          chk("stop_bit", tx, 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_byte: got %02h expected no frame (cycle %0d)", rx, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("rx_byte", rx, e);
          end
          active = 0;
        end
      end
    end
  end

  initial begin
    int rate;
    repeat (3) step();
    rst = 1'b0;
    idle(2);

    // Single byte 'A'.
    write(4'b0001, 32'h0000_0041, 1'b0);
    idle(50);

    // Sparse lanes: 0x22 then 0x44, back to back.
    fall_q.delete();
    write(4'b1010, 32'h4433_2211, 1'b0);
    idle(90);
    chk("frame_count", fall_q.size(), 2);
    if (fall_q.size() == 2) chk("frame_spacing", fall_q[1] - fall_q[0], 10*CPB + 1);

    // Fill, then a write with no room while the first frame holds the line.
    write(4'b1111, 32'h6463_6261, 1'b0);
    write(4'b0001, 32'h0000_0065, 1'b0);
    chk("ovf_after_drop", overflow, 1);
    chk("free_after_pop", free_slots, 1);
    idle(5);
    chk("free_stalled", free_slots, 1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // New overflow wins over a same-cycle clear.
    write(4'b0011, 32'h0000_7877, 1'b1);
    chk("ovf_priority", overflow, 1);
    idle(4*(10*CPB + 1) + 20);

    // Reset in the middle of DATA bit 3 with bytes still queued.
    write(4'b0011, 32'h0000_5ac3, 1'b0);
    idle(17);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_tx", tx, 1);
    chk("rst_free", free_slots, DEPTH);
    chk("rst_busy", busy, 0);
    fall_q.delete();
    idle(100);
    chk("no_frames_after_rst", fall_q.size(), 0);

    // Random traffic: a light phase, then a heavy phase that forces drops.
    for (int i = 0; i < 3000; i++) begin
      rate    = (i < 1500) ? 2 : 30;
      wEn     = ($urandom_range(0, 99) < rate);
      byte_en = 4'($urandom);
      data    = $urandom;
      clr_ovf = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    idle((DEPTH + 2) * (10*CPB + 1));
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
